// File: rtl/mem_sequencer.sv
// mem_sequencer: sequences byte writes into an external 4x8 latch memory
// (store pulse followed by a hold cycle) and streams the stored bytes back
// out over a valid/ready interface on request.
module mem_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       start_scan,
  output logic [7:0] mem_data,
  output logic [1:0] mem_address,
  output logic       mem_store,
  input  logic [7:0] mem_out,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] count,
  output logic       full,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STORE   = 3'd1,
    HOLD    = 3'd2,
    ADDR    = 3'd3,
    PRESENT = 3'd4
  } state_t;

  state_t     state_r;
  logic [2:0] count_r;
  logic [1:0] wr_ptr_r;
  logic [1:0] rd_idx_r;
  logic [7:0] mem_data_r;
  logic [1:0] mem_address_r;
  logic       mem_store_r;
  logic [7:0] out_data_r;
  logic       out_valid_r;

  logic       in_ready_s;
  logic       accept_s;
  logic       last_s;

  // Status flags decode straight from registered state so they never glitch.
  assign in_ready_s = (state_r == IDLE) && (count_r < 3'd4);
  assign accept_s   = in_valid && in_ready_s;
  // The final stored byte is the one at index count-1.
  assign last_s     = ({1'b0, rd_idx_r} == (count_r - 3'd1));

  assign in_ready    = in_ready_s;
  assign full        = (count_r == 3'd4);
  assign busy        = (state_r != IDLE);
  assign count       = count_r;
  assign mem_data    = mem_data_r;
  assign mem_address = mem_address_r;
  assign mem_store   = mem_store_r;
  assign out_data    = out_data_r;
  assign out_valid   = out_valid_r;

  // Sequencer FSM with all memory-side and read-side outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      count_r       <= 3'd0;
      wr_ptr_r      <= 2'd0;
      rd_idx_r      <= 2'd0;
      mem_data_r    <= 8'd0;
      mem_address_r <= 2'd0;
      mem_store_r   <= 1'b0;
      out_data_r    <= 8'd0;
      out_valid_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            // A write always wins over a scan request in the same cycle.
            mem_data_r    <= in_data;
            mem_address_r <= wr_ptr_r;
            mem_store_r   <= 1'b1;
            state_r       <= STORE;
          end else if (start_scan && (count_r != 3'd0)) begin
            rd_idx_r      <= 2'd0;
            mem_address_r <= 2'd0;
            state_r       <= ADDR;
          end else begin
            mem_address_r <= wr_ptr_r;
          end
        end
        STORE: begin
          // Drop the write enable but keep address/data for latch hold time.
          mem_store_r <= 1'b0;
          state_r     <= HOLD;
        end
        HOLD: begin
          count_r       <= count_r + 3'd1;
          wr_ptr_r      <= wr_ptr_r + 2'd1;
          mem_address_r <= wr_ptr_r + 2'd1;
          state_r       <= IDLE;
        end
        ADDR: begin
          // Memory read is combinational; capture it at the end of this cycle.
          out_data_r  <= mem_out;
          out_valid_r <= 1'b1;
          state_r     <= PRESENT;
        end
        PRESENT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (last_s) begin
              // A full read-back empties the memory logically.
              count_r       <= 3'd0;
              wr_ptr_r      <= 2'd0;
              mem_address_r <= 2'd0;
              state_r       <= IDLE;
            end else begin
              rd_idx_r      <= rd_idx_r + 2'd1;
              mem_address_r <= rd_idx_r + 2'd1;
              state_r       <= ADDR;
            end
          end else begin
            state_r <= PRESENT;
          end
        end
        default: begin
          mem_store_r <= 1'b0;
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule
